// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle HI/LO multiply/divide unit with fixed latency and stall request
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_hi, r_lo, r_phi, r_plo;
    logic          r_pwe;
    logic          w_idle_start, w_go, w_done, w_sgn, w_a_neg, w_b_neg, w_bz;
    logic [31:0]   w_a_mag, w_b_mag, w_divisor, w_uq, w_ur, w_q, w_r;
    logic [63:0]   w_prod;

    assign w_idle_start = (r_state == IDLE) && start;
    assign w_go         = w_idle_start && !op[2];
    assign w_done       = (r_state == BUSY) && (r_cnt == CW'(1));
    assign w_sgn        = !op[0];
    assign w_a_neg      = w_sgn && a[31];
    assign w_b_neg      = w_sgn && b[31];
    assign w_bz         = (b == 32'd0);

    // Divide on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing
    assign w_a_mag   = w_a_neg ? -a : a;
    assign w_b_mag   = w_b_neg ? -b : b;
    assign w_divisor = w_bz ? 32'd1 : w_b_mag;
    assign w_uq      = w_a_mag / w_divisor;
    assign w_ur      = w_a_mag % w_divisor;
    assign w_q       = (w_a_neg ^ w_b_neg) ? -w_uq : w_uq;
    assign w_r       = w_a_neg ? -w_ur : w_ur;
    assign w_prod    = {{32{w_a_neg & 1'b1 ? 1'b1 : 1'b0}}, a} * {{32{w_b_neg}}, b};

    assign busy      = (r_state == BUSY);
    assign stall_req = busy || (start && !op[2]);
    assign hi        = r_hi;
    assign lo        = r_lo;

    // Next state: launch from IDLE, return when the counter expires
    always_comb begin
        w_state_nxt = w_go ? BUSY : (w_done ? IDLE : r_state);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Counter, pending results and architectural HI/LO
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
            r_phi <= '0;
            r_plo <= '0;
            r_pwe <= 1'b0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (w_go) begin
                r_cnt <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                r_phi <= op[1] ? w_r : w_prod[63:32];
                r_plo <= op[1] ? w_q : w_prod[31:0];
                r_pwe <= !(op[1] && w_bz);
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_done && r_pwe) begin
                r_hi <= r_phi;
                r_lo <= r_plo;
            end
            if (w_idle_start && op == 3'd4)
                r_hi <= a;
            if (w_idle_start && op == 3'd5)
                r_lo <= a;
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: table, corner-case and randomized checks of mul_div_unit
module tb_mul_div_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd7;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, stall_req;
    logic [31:0] hi, lo;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        int          cyc;
    } vec_t;

    vec_t tbl[10];

    mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", nm, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int cyc);
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        #1;
        chk("stall_start", {31'b0, stall_req}, {31'b0, o <= 3'd3});
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 3'd7;
        cyc = 0;
        while (busy && cyc < 200) begin
            if (!stall_req) chk("stall_busy", {31'b0, stall_req}, 32'd1);
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         inout logic [31:0] mh, inout logic [31:0] ml, output int cyc);
        longint sa, sb, q, r;
        logic [63:0] p;
        cyc = 0;
        case (o)
            3'd0: begin
                p = longint'($signed(x)) * longint'($signed(y));
                mh = p[63:32]; ml = p[31:0]; cyc = MC;
            end
            3'd1: begin
                p = {32'b0, x} * {32'b0, y};
                mh = p[63:32]; ml = p[31:0]; cyc = MC;
            end
            3'd2: begin
                cyc = DC;
                if (y != 0) begin
                    sa = longint'($signed(x)); sb = longint'($signed(y));
                    q = sa / sb; r = sa % sb;
                    mh = r[31:0]; ml = q[31:0];
                end
            end
            3'd3: begin
                cyc = DC;
                if (y != 0) begin
                    mh = x % y; ml = x / y;
                end
            end
            3'd4: mh = x;
            3'd5: ml = x;
            default: ;
        endcase
    endtask

    initial begin
        int cyc, ecyc;
        logic [31:0] mh, ml, x, y;
        logic [2:0] o;
        logic bad_b, bad_h, bad_l;

        tbl[0] = '{3'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, MC};
        tbl[1] = '{3'd1, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, MC};
        tbl[2] = '{3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        tbl[3] = '{3'd3, 32'd7, 32'd2, 32'd1, 32'd3, DC};
        tbl[4] = '{3'd4, 32'h11, 32'd0, 32'h11, 32'd3, 0};
        tbl[5] = '{3'd5, 32'h22, 32'd0, 32'h11, 32'h22, 0};
        tbl[6] = '{3'd2, 32'h1234, 32'd0, 32'h11, 32'h22, DC};
        tbl[7] = '{3'd6, 32'h5555, 32'd9, 32'h11, 32'h22, 0};
        tbl[8] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, DC};
        tbl[9] = '{3'd3, 32'd0, 32'd0, 32'h0, 32'h80000000, DC};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("idle_stall", {31'b0, stall_req}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, cyc);
            chk($sformatf("tbl%0d_cyc", i), cyc, tbl[i].cyc);
            chk($sformatf("tbl%0d_hi", i), hi, tbl[i].hi);
            chk($sformatf("tbl%0d_lo", i), lo, tbl[i].lo);
        end

        // MTHI while a multiply is in flight is dropped
        do_reset();
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'hDEAD;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'd7;
        chk("hold_hi_busy", hi, 32'd0);
        chk("hold_lo_busy", lo, 32'd0);
        cyc = 2;
        while (busy && cyc < 100) begin
            cyc++;
            @(posedge clk);
            #1;
        end
        chk("mthi_busy_cyc", cyc, MC);
        chk("mthi_busy_hi", hi, 32'd0);
        chk("mthi_busy_lo", lo, 32'hC);

        // start on the completing edge is ignored
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (MC - 1) @(posedge clk);
        @(negedge clk);
        chk("last_busy", {31'b0, busy}, 32'd1);
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'd7;
        chk("edge_start_busy", {31'b0, busy}, 32'd0);
        chk("edge_start_lo", lo, 32'd6);
        @(posedge clk);
        #1;
        chk("edge_start_busy2", {31'b0, busy}, 32'd0);

        // reset mid-divide aborts it
        do_op(3'd4, 32'd5, 32'd0, cyc);
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'd7;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        bad_b = 0; bad_h = 0; bad_l = 0;
        for (int i = 0; i < DC; i++) begin
            @(posedge clk);
            #1;
            bad_b |= busy; bad_h |= (hi != 0); bad_l |= (lo != 0);
        end
        chk("abort_hold_busy", {31'b0, bad_b}, 32'd0);
        chk("abort_hold_hi", {31'b0, bad_h}, 32'd0);
        chk("abort_hold_lo", {31'b0, bad_l}, 32'd0);

        // reset beats start on the same edge
        @(negedge clk);
        reset = 1'b0; start = 1'b1; op = 3'd4; a = 32'h77;
        @(posedge clk);
        #1;
        reset = 1'b1; start = 1'b0; op = 3'd7;
        chk("rst_prio_hi", hi, 32'd0);

        // randomized against the arithmetic model
        mh = 0; ml = 0;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
            if ($urandom_range(0, 3) == 0) x = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 31'($urandom_range(0, 1000))};
            model(o, x, y, mh, ml, ecyc);
            do_op(o, x, y, cyc);
            chk($sformatf("rnd%0d_cyc op%0d", i, o), cyc, ecyc);
            chk($sformatf("rnd%0d_hi op%0d", i, o), hi, mh);
            chk($sformatf("rnd%0d_lo op%0d", i, o), lo, ml);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
